console_rx: RTL and testbench
=============================

Name: console_rx

Overview:
UART receiver for the console line, the receive-side counterpart of the console transmitter used by the CPU's B2 write instruction. It samples the serial input, deframes 8N1 bytes, and buffers them in a small FIFO. The CPU reads bytes through a register-style interface with the same conventions as the console TX block: a 32-bit divider register and a data register that returns all-ones when empty. It sits beside the console TX on the top level, with SER_RX driven from PIN_2.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; power of two, minimum 2
DIV_RESET, 53333, divider value after reset (16 MHz / 300 baud)

Ports:
CLK  input  1  system clock, 16 MHz
RST  input  1  reset; synchronous, active-high
SER_RX  input  1  asynchronous serial line, idle high
DIV_WE  input  4  byte enables for a DIV_DI write; bit n writes byte n
DIV_DI  input  32  divider write data
DIV_DO  output  32  current divider value
DAT_RE  input  1  pop one byte; single-cycle pulse
DAT_DO  output  32  {24'h0, head byte} when the FIFO is not empty, else 32'hFFFFFFFF
RX_VALID  output  1  FIFO not empty
RX_OVERRUN  output  1  sticky; a byte was dropped because the FIFO was full
FRAME_ERR  output  1  sticky; a stop bit was sampled low
ERR_CLR  input  1  clears RX_OVERRUN and FRAME_ERR

Behaviour:
- Reset values: divider = DIV_RESET, FIFO empty, RX_VALID=0, DAT_DO=32'hFFFFFFFF, RX_OVERRUN=0, FRAME_ERR=0, FSM=IDLE, synchroniser flops=1.
- SER_RX passes through a 2-flop synchroniser (sync). The FSM sees only sync.
- Divider register:
  - Each byte whose DIV_WE bit is set is written on the next edge.
  - The FSM latches the divider into an internal copy when it enters START. A divider write mid-frame affects only the next frame.
  - An effective divider below 4 is treated as 4.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. cnt is the cycle counter; bitn is the bit index, 0..7.
  - IDLE: when sync==0, go to START and set cnt=floor(div/2)-1.
  - START: decrement cnt. At 0, sample sync.
    - Sample 1 (glitch): go to IDLE.
    - Sample 0: go to DATA, set bitn=0, cnt=div-1.
  - DATA: at cnt 0, shift sync into bit bitn (LSB first) and reload cnt=div-1. After bitn=7, go to STOP.
  - STOP: at cnt 0, sample sync.
    - Sample 1: push the byte and go to IDLE.
    - Sample 0: set FRAME_ERR, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until sync==1, then go to IDLE. A break does not produce repeated frames.
- Timing: RX_VALID rises exactly 2 + floor(div/2) + 9*div + 1 cycles after the SER_RX falling edge, when the FIFO was empty.
- FIFO:
  - Pointers wrap modulo FIFO_DEPTH. An occupancy counter is 0..FIFO_DEPTH.
  - Push to a full FIFO without a same-cycle pop: byte dropped, RX_OVERRUN set, contents unchanged.
  - DAT_RE with the FIFO not empty: head advances on that edge. DAT_DO is combinational from the head, so the value presented in the DAT_RE cycle is the byte consumed.
  - DAT_RE on an empty FIFO is ignored; no underflow and no state change.
  - Push and pop in the same cycle: both take effect, occupancy unchanged. This applies even when full, so no overrun.
- Sticky errors:
  - ERR_CLR clears both flags.
  - If a new error and ERR_CLR occur in the same cycle, the set wins.
- RST mid-frame: abort the frame, discard partial data, flush the FIFO, restore DIV_RESET. Reset has priority over every other input.

Test Plan:
- Reset, then divider write DIV_WE=4'b1111, DIV_DI=16 -> DIV_DO=16. Send 8N1 0x55 -> RX_VALID rises exactly 2+8+144+1=155 cycles after the falling edge; DAT_DO=32'h00000055. Pulse DAT_RE -> RX_VALID=0, DAT_DO=32'hFFFFFFFF.
- Divider 16. 3-cycle low glitch on SER_RX -> no byte pushed, FSM back in IDLE. Then 0xA3 -> DAT_DO=32'h000000A3.
- Divider 16. Send 0x00..0x08 (9 bytes) with no reads -> RX_OVERRUN=1; pop 8 times and read 0x00..0x07; 9th DAT_DO=32'hFFFFFFFF. ERR_CLR -> RX_OVERRUN=0.
- Divider 16. Frame 0x41 with stop bit held low for 40 cycles -> FRAME_ERR=1, no byte pushed, FSM waits for the line high. Next 0x42 is received correctly.
- Divider 16. FIFO full; DAT_RE pulsed in the exact push cycle of a 9th byte -> RX_OVERRUN stays 0, occupancy 8, head advances.
- Mid-frame (bit 4 of 0x7E), RST for 1 cycle -> FIFO empty, DIV_DO=53333, no byte pushed from the truncated frame.

Source files
------------

// File: rtl/console_rx.sv
// Console UART receiver: 2-flop input synchroniser, 8N1 deframer with a
// per-frame latched divider, and a small receive FIFO read through a
// register-style interface (32-bit divider, all-ones data when empty).
module console_rx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] DIV_RESET  = 32'd53333
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SER_RX,
  input  logic [3:0]  DIV_WE,
  input  logic [31:0] DIV_DI,
  output logic [31:0] DIV_DO,
  input  logic        DAT_RE,
  output logic [31:0] DAT_DO,
  output logic        RX_VALID,
  output logic        RX_OVERRUN,
  output logic        FRAME_ERR,
  input  logic        ERR_CLR
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser; idles high so reset never looks like a start bit
  // ---------------------------------------------------------------------
  logic [1:0] sync_pipe;
  logic       sync;

  // Two-stage capture of the asynchronous serial line
  always_ff @(posedge CLK) begin
    if (RST) sync_pipe <= 2'b11;
    else     sync_pipe <= {sync_pipe[0], SER_RX};
  end

  assign sync = sync_pipe[1];

  // ---------------------------------------------------------------------
  // Divider register with per-byte write enables
  // ---------------------------------------------------------------------
  logic [31:0] div;
  logic [31:0] div_eff;

  // Byte-lane writes into the divider
  always_ff @(posedge CLK) begin
    if (RST) begin
      div <= DIV_RESET;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (DIV_WE[i]) div[8*i +: 8] <= DIV_DI[8*i +: 8];
      end
    end
  end

  assign DIV_DO  = div;
  // Tiny dividers leave no room for a mid-bit sample; clamp to 4
  assign div_eff = (div < 32'd4) ? 32'd4 : div;

  // ---------------------------------------------------------------------
  // Deframer FSM
  // ---------------------------------------------------------------------
  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] div_q, div_q_n;
  logic [2:0]  bitn, bitn_n;
  logic [7:0]  shreg, shreg_n;
  logic        push;
  logic        ferr_set;

  // FSM state and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      div_q <= DIV_RESET;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      div_q <= div_q_n;
      bitn  <= bitn_n;
      shreg <= shreg_n;
    end
  end

  // Next-state logic; div_q freezes the divider for the whole frame
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_q_n  = div_q;
    bitn_n   = bitn;
    shreg_n  = shreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (!sync) begin
          state_n = START;
          div_q_n = div_eff;
          cnt_n   = (div_eff >> 1) - 32'd1;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (sync) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            bitn_n  = '0;
            cnt_n   = div_q - 32'd1;
          end
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_n = {sync, shreg[7:1]};
          cnt_n   = div_q - 32'd1;
          if (bitn == 3'd7) state_n = STOP;
          else              bitn_n  = bitn + 3'd1;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (sync) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      WAIT_HIGH: begin
        if (sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, wr_en, ovr_set;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop     = DAT_RE && !empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push
  assign wr_en   = push && (!full || pop);
  assign ovr_set = push && full && !pop;

  // Storage array; contents need no reset since occupancy gates reads
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem[wr_ptr] <= shreg;
  end

  // Pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign RX_VALID = !empty;
  assign DAT_DO   = empty ? 32'hFFFF_FFFF : {24'h0, mem[rd_ptr]};

  // ---------------------------------------------------------------------
  // Sticky error flags; a new error beats a same-cycle clear
  // ---------------------------------------------------------------------

  // Overrun and framing error flags
  always_ff @(posedge CLK) begin
    if (RST) begin
      RX_OVERRUN <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      if (ERR_CLR) begin
        RX_OVERRUN <= 1'b0;
        FRAME_ERR  <= 1'b0;
      end
      if (ovr_set)  RX_OVERRUN <= 1'b1;
      if (ferr_set) FRAME_ERR  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_console_rx.sv
// Bench for console_rx: divider writes and clean frames from tables, then
// hand-built sequences for glitch, overrun, framing error, push/pop
// collision and mid-frame reset.
module tb_console_rx;

  logic        CLK = 1'b0;
  logic        RST, SER_RX, DAT_RE, ERR_CLR;
  logic [3:0]  DIV_WE;
  logic [31:0] DIV_DI, DIV_DO, DAT_DO;
  logic        RX_VALID, RX_OVERRUN, FRAME_ERR;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int DIVT = 16;

  console_rx dut (
    .CLK(CLK), .RST(RST), .SER_RX(SER_RX),
    .DIV_WE(DIV_WE), .DIV_DI(DIV_DI), .DIV_DO(DIV_DO),
    .DAT_RE(DAT_RE), .DAT_DO(DAT_DO),
    .RX_VALID(RX_VALID), .RX_OVERRUN(RX_OVERRUN), .FRAME_ERR(FRAME_ERR),
    .ERR_CLR(ERR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] di;
    logic [31:0] exp_div;
  } div_vec_t;

  typedef struct {
    logic [7:0]  b;
    logic [31:0] exp_do;
  } byte_vec_t;

  div_vec_t  dv [6];
  byte_vec_t bv [4];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line level before clock edge c (1-based) of a frame with bit time DIVT
  function automatic logic line_at(input logic [7:0] b, input int c, input logic stop_val);
    if (c <= DIVT)     return 1'b0;
    if (c <= 9 * DIVT) return b[(c - 1) / DIVT - 1];
    return stop_val;
  endfunction

  // Drive one frame; optional DAT_RE / ERR_CLR pulse on a chosen edge;
  // reports the edge on which RX_VALID first rose (-1 if it did not)
  task automatic send(input logic [7:0] b, input int stop_len, input logic stop_val,
                      input int pop_at, input int clr_at, output int rise);
    logic prev;
    rise = -1;
    prev = RX_VALID;
    for (int c = 1; c <= 9 * DIVT + stop_len; c++) begin
      SER_RX  = line_at(b, c, stop_val);
      DAT_RE  = (c == pop_at);
      ERR_CLR = (c == clr_at);
      tick();
      if (rise < 0 && !prev && RX_VALID) rise = c;
      prev = RX_VALID;
    end
    SER_RX  = 1'b1;
    DAT_RE  = 1'b0;
    ERR_CLR = 1'b0;
  endtask

  task automatic sendb(input logic [7:0] b);
    int r;
    send(b, DIVT, 1'b1, -1, -1, r);
    tick();
    tick();
  endtask

  task automatic pop();
    DAT_RE = 1'b1;
    tick();
    DAT_RE = 1'b0;
  endtask

  initial begin
    int r;
    dv[0] = '{4'b0001, 32'h1234_5678, 32'h0000_D078};
    dv[1] = '{4'b0010, 32'hAABB_CCDD, 32'h0000_CC78};
    dv[2] = '{4'b0100, 32'h1122_3344, 32'h0022_CC78};
    dv[3] = '{4'b1000, 32'h9900_0000, 32'h9922_CC78};
    dv[4] = '{4'b0000, 32'hFFFF_FFFF, 32'h9922_CC78};
    dv[5] = '{4'b1111, 32'h0000_0010, 32'h0000_0010};
    bv[0] = '{8'hFF, 32'h0000_00FF};
    bv[1] = '{8'h01, 32'h0000_0001};
    bv[2] = '{8'h80, 32'h0000_0080};
    bv[3] = '{8'hC3, 32'h0000_00C3};

    RST = 1'b1; SER_RX = 1'b1; DAT_RE = 1'b0; ERR_CLR = 1'b0;
    DIV_WE = '0; DIV_DI = '0;
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Reset state
    chk("rst_div", DIV_DO, 32'd53333);
    chk("rst_valid", 32'(RX_VALID), 32'd0);
    chk("rst_dat", DAT_DO, 32'hFFFF_FFFF);
    chk("rst_ovr", 32'(RX_OVERRUN), 32'd0);
    chk("rst_ferr", 32'(FRAME_ERR), 32'd0);

    // Divider byte-lane writes, ending at 16
    for (int i = 0; i < 6; i++) begin
      DIV_WE = dv[i].we;
      DIV_DI = dv[i].di;
      tick();
      DIV_WE = '0;
      chk($sformatf("div_wr%0d", i), DIV_DO, dv[i].exp_div);
    end

    // 0x55 with exact RX_VALID latency
    send(8'h55, DIVT, 1'b1, -1, -1, r);
    chk("lat_55", 32'(r), 32'd155);
    chk("valid_55", 32'(RX_VALID), 32'd1);
    chk("dat_55", DAT_DO, 32'h0000_0055);
    pop();
    chk("pop_valid", 32'(RX_VALID), 32'd0);
    chk("pop_dat", DAT_DO, 32'hFFFF_FFFF);
    pop();
    chk("empty_pop_dat", DAT_DO, 32'hFFFF_FFFF);
    chk("empty_pop_valid", 32'(RX_VALID), 32'd0);

    // Clean frames from the table
    for (int i = 0; i < 4; i++) begin
      sendb(bv[i].b);
      chk($sformatf("byte%0d_dat", i), DAT_DO, bv[i].exp_do);
      pop();
      chk($sformatf("byte%0d_empty", i), 32'(RX_VALID), 32'd0);
    end

    // Short low glitch is rejected, next frame fine
    SER_RX = 1'b0;
    repeat (3) tick();
    SER_RX = 1'b1;
    repeat (40) tick();
    chk("glitch_nopush", 32'(RX_VALID), 32'd0);
    sendb(8'hA3);
    chk("after_glitch", DAT_DO, 32'h0000_00A3);
    pop();
    chk("after_glitch_empty", 32'(RX_VALID), 32'd0);

    // Overrun: 9 bytes into 8 entries
    for (int i = 0; i < 9; i++) begin
      sendb(8'(i));
      if (i == 7) chk("full_no_ovr", 32'(RX_OVERRUN), 32'd0);
    end
    chk("ovr_set", 32'(RX_OVERRUN), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovr_rd%0d", i), DAT_DO, 32'(i));
      pop();
    end
    chk("ovr_drained", DAT_DO, 32'hFFFF_FFFF);
    chk("ovr_drained_valid", 32'(RX_VALID), 32'd0);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("ovr_clr", 32'(RX_OVERRUN), 32'd0);

    // Framing error, with ERR_CLR colliding on the setting edge
    send(8'h41, 40, 1'b0, -1, 155, r);
    repeat (4) tick();
    chk("ferr_set", 32'(FRAME_ERR), 32'd1);
    chk("ferr_nopush", 32'(RX_VALID), 32'd0);
    sendb(8'h42);
    chk("after_ferr", DAT_DO, 32'h0000_0042);
    pop();
    chk("after_ferr_empty", 32'(RX_VALID), 32'd0);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("ferr_clr", 32'(FRAME_ERR), 32'd0);

    // Full FIFO, pop on the exact push edge of a 9th byte
    for (int i = 0; i < 8; i++) sendb(8'h10 + 8'(i));
    send(8'h18, DIVT, 1'b1, 155, -1, r);
    tick();
    tick();
    chk("pp_no_ovr", 32'(RX_OVERRUN), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("pp_rd%0d", k), DAT_DO, 32'h10 + 32'(k));
      pop();
    end
    chk("pp_drained", DAT_DO, 32'hFFFF_FFFF);

    // Reset in the middle of bit 4 of 0x7E, with a byte already queued
    sendb(8'h99);
    for (int c = 1; c <= 5 * DIVT + 8; c++) begin
      SER_RX = line_at(8'h7E, c, 1'b1);
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    SER_RX = 1'b1;
    chk("mrst_valid", 32'(RX_VALID), 32'd0);
    chk("mrst_dat", DAT_DO, 32'hFFFF_FFFF);
    chk("mrst_div", DIV_DO, 32'd53333);
    repeat (200) tick();
    chk("mrst_nopush", 32'(RX_VALID), 32'd0);
    chk("mrst_ferr", 32'(FRAME_ERR), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
